cla_seq_adder: RTL and testbench
================================

CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/sum width in bits.
REQ-002 SHALL have parameter GROUP, default 4: lookahead group width in bits; NG = WIDTH/GROUP groups.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request; sampled on rising clk edge.
REQ-006 SHALL have port a, input, WIDTH: operand A.
REQ-007 SHALL have port b, input, WIDTH: operand B.
REQ-008 SHALL have port cin, input, 1: carry-in.
REQ-009 SHALL have port busy, output, 1: high while in CALC.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port sum, output, WIDTH: registered result.
REQ-012 SHALL have port cout, output, 1: registered carry-out.
REQ-013 SHALL have port g_all, output, 1: registered block generate of the whole word.
REQ-014 SHALL have port p_all, output, 1: registered block propagate of the whole word (AND of all bit propagates).
REQ-015 SHALL have port ovf, output, 1, present only under CLA_OVF_EN: signed overflow.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE.
- IDLE: start=1 -> CALC, latch a, b, cin, set group index 0.
- CALC: one group per cycle; after group NG-1 -> DONE.
- DONE: start=1 -> CALC, new operands latched; else -> IDLE.
REQ-017 Per CALC cycle SHALL compute bit g=a&b and p=a^b for the indexed GROUP-bit slice, all slice carries by lookahead from the running group carry, and store the slice sum and slice carry-out into internal registers.
REQ-018 Running group carry SHALL equal latched cin for group 0, then the previous group's carry-out.
REQ-019 Latency: start sampled at edge t -> done=1 during the cycle after edge t+NG; busy=1 during cycles after edges t..t+NG-1.
REQ-020 sum, cout, g_all, p_all (and ovf) SHALL update only on the edge entering DONE and hold until the next completion.
REQ-021 cout SHALL equal g_all | (p_all & cin_latched); sum SHALL equal (a+b+cin) mod 2^WIDTH.
REQ-022 start while in CALC SHALL be ignored; operands changing during CALC SHALL not affect the result.
REQ-023 start in DONE SHALL be accepted (back-to-back), done still pulsing that cycle.
REQ-024 done SHALL never be high for two consecutive cycles unless NG=1 and start is held high.
REQ-025 WIDTH not an integer multiple of GROUP, or GROUP < 1, SHALL fail elaboration.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE; busy, done, sum, cout, g_all, p_all, ovf, group index and internal registers SHALL be 0.
REQ-027 Reset during CALC SHALL abort the operation; no done pulse and no output update SHALL follow release.
REQ-028 First start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-029 Macro CLA_OVF_EN defined: ovf port exists, registered with sum; ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]) on latched operands.
REQ-030 Macro CLA_OVF_EN undefined: ovf port and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=16, GROUP=4)
REQ-031 a=FFFF, b=0001, cin=0, start 1 cycle -> busy 4 cycles, done in 5th cycle, sum=0000, cout=1, g_all=1, p_all=0.
REQ-032 a=AAAA, b=5555, cin=1 -> sum=0000, cout=1, p_all=1, g_all=0; with cin=0 -> sum=FFFF, cout=0.
REQ-033 start pulsed again during CALC and a/b changed mid-CALC -> ignored; result equals first operands, single done.
REQ-034 rst_n low in 2nd CALC cycle -> all outputs 0 immediately, no done after release; next start gives correct result.
REQ-035 start held high through DONE with a=1234, b=4321 then a=0001, b=0001 -> done pulses 5 cycles apart; sums 5555 then 0002.
REQ-036 CLA_OVF_EN defined: a=7FFF, b=0001 -> ovf=1, sum=8000; a=8000, b=FFFF -> ovf=1, sum=7FFF, cout=1.

Source files
------------

// File: rtl/cla_seq_adder.sv
// -----------------------------------------------------------------------------
// cla_seq_adder
//    Sequential carry-lookahead adder. A request latches both operands and the
//    carry-in, then one GROUP-bit slice is added per clock. Inside a slice, all
//    carries come from flattened lookahead terms. Between slices, the carry
//    ripples through a register. When the last slice is done, the word result
//    and the block generate/propagate are registered. done then pulses for one
//    cycle.
//
// Parameters
//    WIDTH  operand/sum width (must be a multiple of GROUP)
//    GROUP  lookahead group width, NG = WIDTH/GROUP slices
//
// Ports
//    clk    rising-edge clock
//    rst_n  asynchronous active-low reset
//    start  request, accepted in IDLE or DONE
//    a, b   operands, WIDTH bits
//    cin    carry-in
//    busy   high while a slice is being processed (CALC)
//    done   one-cycle completion pulse
//    sum    registered (a+b+cin) mod 2^WIDTH
//    cout   registered carry-out
//    g_all  registered block generate of the whole word
//    p_all  registered block propagate of the whole word
//    ovf    registered signed overflow, present only when CLA_OVF_EN is defined
//
// Build option
//    CLA_OVF_EN  adds the ovf output and its logic
// -----------------------------------------------------------------------------
module cla_seq_adder #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             g_all,
   output logic             p_all
`ifdef CLA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NG = (GROUP > 0) ? (WIDTH / GROUP) : 1;
   localparam int IW = (NG > 1) ? $clog2(NG) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NG - 1);
   localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({GROUP{1'b1}});

   generate
      if (GROUP < 1) begin : g_bad_group
         $error("cla_seq_adder: GROUP must be at least 1");
      end else if ((WIDTH % GROUP) != 0) begin : g_bad_width
         $error("cla_seq_adder: WIDTH must be a multiple of GROUP");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nx_s;
   logic              load_s;

   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic              cin_r;
   logic              carry_r;
   logic [IW-1:0]     grp_idx_r;
   logic [WIDTH-1:0]  sum_acc_r;
   logic              g_acc_r;
   logic              p_acc_r;

   logic [31:0]       shamt_s;
   logic [GROUP-1:0]  slice_a_s;
   logic [GROUP-1:0]  slice_b_s;
   logic [GROUP-1:0]  g_s;
   logic [GROUP-1:0]  p_s;
   logic [GROUP:0]    c_s;
   logic [GROUP-1:0]  slice_sum_s;
   logic              grp_g_s;
   logic              grp_p_s;
   logic [WIDTH-1:0]  sum_acc_nx_s;
   logic              g_acc_nx_s;
   logic              p_acc_nx_s;
   logic              pp_s;
   logic              cv_s;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic and operand-load decision.
   always_comb begin
      state_nx_s = state_r;
      load_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s = ST_CALC;
               load_s     = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            // start is deliberately not looked at here
            if (grp_idx_r == LAST_IDX) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_CALC;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_nx_s = ST_CALC;
               load_s     = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Slice datapath: select the indexed slice and compute lookahead carries.
   always_comb begin
      shamt_s   = 32'(grp_idx_r) * 32'(GROUP);
      slice_a_s = GROUP'(a_r >> shamt_s);
      slice_b_s = GROUP'(b_r >> shamt_s);
      g_s       = slice_a_s & slice_b_s;
      p_s       = slice_a_s ^ slice_b_s;
      pp_s      = 1'b0;
      cv_s      = 1'b0;
      c_s       = '0;
      c_s[0]    = carry_r;
      // c[i+1] = p[i..0]&c0 | sum over j of g[j]&p[i..j+1], fully expanded
      for (int i = 0; i < GROUP; i++) begin
         cv_s = carry_r;
         for (int j = 0; j <= i; j++) begin
            cv_s = cv_s & p_s[j];
         end
         for (int j = 0; j <= i; j++) begin
            pp_s = g_s[j];
            for (int k = j + 1; k <= i; k++) begin
               pp_s = pp_s & p_s[k];
            end
            cv_s = cv_s | pp_s;
         end
         c_s[i+1] = cv_s;
      end
      // Group generate: the same expansion without the incoming carry
      grp_g_s = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
         pp_s = g_s[j];
         for (int k = j + 1; k < GROUP; k++) begin
            pp_s = pp_s & p_s[k];
         end
         grp_g_s = grp_g_s | pp_s;
      end
      grp_p_s      = &p_s;
      slice_sum_s  = p_s ^ c_s[GROUP-1:0];
      sum_acc_nx_s = (sum_acc_r & ~(SLICE_MASK << shamt_s))
                   | (WIDTH'(slice_sum_s) << shamt_s);
      // Fold this slice (higher order) over the groups already processed
      g_acc_nx_s   = grp_g_s | (grp_p_s & g_acc_r);
      p_acc_nx_s   = grp_p_s & p_acc_r;
   end

   // Operand latch, slice accumulation, and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r       <= '0;
         b_r       <= '0;
         cin_r     <= 1'b0;
         carry_r   <= 1'b0;
         grp_idx_r <= '0;
         sum_acc_r <= '0;
         g_acc_r   <= 1'b0;
         p_acc_r   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         g_all     <= 1'b0;
         p_all     <= 1'b0;
`ifdef CLA_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         busy <= (state_nx_s == ST_CALC);
         done <= (state_nx_s == ST_DONE);
         if (load_s) begin
            a_r       <= a;
            b_r       <= b;
            cin_r     <= cin;
            carry_r   <= cin;
            grp_idx_r <= '0;
            sum_acc_r <= '0;
            g_acc_r   <= 1'b0;
            p_acc_r   <= 1'b1;
         end else if (state_r == ST_CALC) begin
            carry_r   <= c_s[GROUP];
            sum_acc_r <= sum_acc_nx_s;
            g_acc_r   <= g_acc_nx_s;
            p_acc_r   <= p_acc_nx_s;
            if (grp_idx_r == LAST_IDX) begin
               grp_idx_r <= '0;
               sum       <= sum_acc_nx_s;
               g_all     <= g_acc_nx_s;
               p_all     <= p_acc_nx_s;
               cout      <= g_acc_nx_s | (p_acc_nx_s & cin_r);
`ifdef CLA_OVF_EN
               ovf       <= (a_r[WIDTH-1] == b_r[WIDTH-1])
                          & (sum_acc_nx_s[WIDTH-1] != a_r[WIDTH-1]);
`endif
            end else begin
               grp_idx_r <= grp_idx_r + IW'(1);
            end
         end else begin
            grp_idx_r <= grp_idx_r;
         end
      end
   end

endmodule

// File: tb/tb_cla_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_seq_adder
//    Self-checking bench for cla_seq_adder (WIDTH=16, GROUP=4). Expected values
//    come from word-level arithmetic in ref_model.
// -----------------------------------------------------------------------------
module tb_cla_seq_adder;

   localparam int WIDTH = 16;
   localparam int GROUP = 4;
   localparam int NG    = WIDTH / GROUP;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [WIDTH-1:0]  a     = '0;
   logic [WIDTH-1:0]  b     = '0;
   logic              cin   = 1'b0;
   logic              busy;
   logic              done;
   logic [WIDTH-1:0]  sum;
   logic              cout;
   logic              g_all;
   logic              p_all;
`ifdef CLA_OVF_EN
   logic              ovf;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   cla_seq_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .g_all (g_all),
      .p_all (p_all)
`ifdef CLA_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Word-level reference: plain integer addition.
   function automatic void ref_model(input logic [15:0] ma, input logic [15:0] mb,
                                     input logic mc, output logic [15:0] es,
                                     output logic ec, output logic eg,
                                     output logic ep, output logic eo);
      logic [16:0] full;
      logic [16:0] nocarry;
      full    = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
      nocarry = {1'b0, ma} + {1'b0, mb};
      es = full[15:0];
      ec = full[16];
      eg = nocarry[16];
      ep = &(ma ^ mb);
      eo = (ma[15] == mb[15]) && (full[15] != ma[15]);
   endfunction

   // Pulse start for one edge; returns in the first cycle after that edge.
   task automatic launch(input logic [15:0] la, input logic [15:0] lb, input logic lc);
      @(negedge clk);
      a = la; b = lb; cin = lc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] es; logic ec, eg, ep, eo;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, sum, cout, g_all, p_all} !== 21'd0) begin
         $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b g=%b p=%b want all 0",
                  busy, done, sum, cout, g_all, p_all);
      end else n_pass++;
`ifdef CLA_OVF_EN
      n_checks++;
      if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf);
      else n_pass++;
`endif
      // Release and request at once: the first edge with rst_n=1 must accept it
      rst_n = 1'b1; a = 16'h0102; b = 16'h0304; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL first_start_accept: got busy=%b want 1", busy);
      else n_pass++;
      repeat (NG) @(negedge clk);
      ref_model(16'h0102, 16'h0304, 1'b0, es, ec, eg, ep, eo);
      n_checks++;
      if (done !== 1'b1 || sum !== es) $display("FAIL first_result: got done=%b sum=%h want 1 %h", done, sum, es);
      else n_pass++;
   endtask

   task automatic test_directed();
      logic [15:0] va [3] = '{16'hFFFF, 16'hAAAA, 16'hAAAA};
      logic [15:0] vb [3] = '{16'h0001, 16'h5555, 16'h5555};
      logic        vc [3] = '{1'b0, 1'b1, 1'b0};
      logic [15:0] vs [3] = '{16'h0000, 16'h0000, 16'hFFFF};
      logic        vo [3] = '{1'b1, 1'b1, 1'b0};
      logic        vg [3] = '{1'b1, 1'b0, 1'b0};
      logic        vp [3] = '{1'b0, 1'b1, 1'b1};
      int busy_cnt;
      for (int t = 0; t < 3; t++) begin
         launch(va[t], vb[t], vc[t]);
         busy_cnt = 0;
         for (int i = 0; i < NG; i++) begin
            if (busy === 1'b1 && done === 1'b0) busy_cnt++;
            @(negedge clk);
         end
         n_checks++;
         if (busy_cnt !== NG) $display("FAIL dir%0d_busy_cycles: got %0d want %0d", t, busy_cnt, NG);
         else n_pass++;
         n_checks++;
         if (done !== 1'b1 || busy !== 1'b0) $display("FAIL dir%0d_done: got done=%b busy=%b want 1 0", t, done, busy);
         else n_pass++;
         n_checks++;
         if ({sum, cout, g_all, p_all} !== {vs[t], vo[t], vg[t], vp[t]})
            $display("FAIL dir%0d_result: got sum=%h cout=%b g=%b p=%b want %h %b %b %b",
                     t, sum, cout, g_all, p_all, vs[t], vo[t], vg[t], vp[t]);
         else n_pass++;
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0 || sum !== vs[t]) $display("FAIL dir%0d_pulse_hold: got done=%b sum=%h want 0 %h", t, done, sum, vs[t]);
         else n_pass++;
      end
   endtask

   task automatic test_ignore_start();
      int done_cnt, first_i;
      logic [15:0] cap;
      launch(16'h1111, 16'h2222, 1'b0);
      done_cnt = 0; first_i = -1; cap = '0;
      for (int i = 1; i <= NG + 6; i++) begin
         if (i == 1) begin
            start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
         end else begin
            start = 1'b0; a = 16'h0F0F; b = 16'h7070;
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (first_i < 0) begin first_i = i; cap = sum; end
         end
         @(negedge clk);
      end
      n_checks++;
      if (done_cnt !== 1 || first_i !== NG + 1)
         $display("FAIL ignore_start_done: got count=%0d at=%0d want 1 at %0d", done_cnt, first_i, NG + 1);
      else n_pass++;
      n_checks++;
      if (cap !== 16'h3333) $display("FAIL ignore_start_sum: got %h want 3333", cap);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int done_cnt;
      logic [15:0] es; logic ec, eg, ep, eo;
      launch(16'hABCD, 16'h1234, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, sum, cout, g_all, p_all} !== 21'd0)
         $display("FAIL midreset_outputs: got busy=%b done=%b sum=%h cout=%b g=%b p=%b want all 0",
                  busy, done, sum, cout, g_all, p_all);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || sum !== 16'h0000) done_cnt++;
      end
      n_checks++;
      if (done_cnt !== 0) $display("FAIL midreset_no_done: got %0d bad cycles want 0", done_cnt);
      else n_pass++;
      launch(16'hABCD, 16'h1234, 1'b1);
      repeat (NG) @(negedge clk);
      ref_model(16'hABCD, 16'h1234, 1'b1, es, ec, eg, ep, eo);
      n_checks++;
      if (done !== 1'b1 || sum !== es || cout !== ec)
         $display("FAIL midreset_recover: got done=%b sum=%h cout=%b want 1 %h %b", done, sum, cout, es, ec);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int first_i, second_i;
      logic prev_done, consec;
      logic [15:0] s1, s2;
      @(negedge clk);
      a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
      first_i = -1; second_i = -1; prev_done = 1'b0; consec = 1'b0; s1 = '0; s2 = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1 && prev_done === 1'b1) consec = 1'b1;
         if (done === 1'b1) begin
            if (first_i < 0) begin
               first_i = i; s1 = sum; a = 16'h0001; b = 16'h0001;
            end else if (second_i < 0) begin
               second_i = i; s2 = sum; start = 1'b0;
            end
         end
         prev_done = done;
      end
      start = 1'b0;
      n_checks++;
      if (first_i !== NG || second_i !== 2 * NG + 1)
         $display("FAIL b2b_timing: got done at %0d,%0d want %0d,%0d", first_i, second_i, NG, 2 * NG + 1);
      else n_pass++;
      n_checks++;
      if (s1 !== 16'h5555 || s2 !== 16'h0002) $display("FAIL b2b_sums: got %h,%h want 5555,0002", s1, s2);
      else n_pass++;
      n_checks++;
      if (consec !== 1'b0) $display("FAIL b2b_done_consecutive: got %b want 0", consec);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [15:0] ra, rb, es; logic rc, ec, eg, ep, eo;
      int busy_cnt;
      for (int t = 0; t < 40; t++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         if (t % 8 == 0) rb = ~ra;
         launch(ra, rb, rc);
         busy_cnt = 0;
         for (int i = 0; i < NG; i++) begin
            if (busy === 1'b1 && done === 1'b0) busy_cnt++;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            @(negedge clk);
         end
         ref_model(ra, rb, rc, es, ec, eg, ep, eo);
         n_checks++;
         if (busy_cnt !== NG || done !== 1'b1)
            $display("FAIL rnd%0d_timing: got busy_cycles=%0d done=%b want %0d 1", t, busy_cnt, done, NG);
         else n_pass++;
         n_checks++;
         if ({sum, cout, g_all, p_all} !== {es, ec, eg, ep})
            $display("FAIL rnd%0d_result a=%h b=%h c=%b: got sum=%h cout=%b g=%b p=%b want %h %b %b %b",
                     t, ra, rb, rc, sum, cout, g_all, p_all, es, ec, eg, ep);
         else n_pass++;
`ifdef CLA_OVF_EN
         n_checks++;
         if (ovf !== eo) $display("FAIL rnd%0d_ovf: got %b want %b", t, ovf, eo);
         else n_pass++;
`endif
      end
   endtask

`ifdef CLA_OVF_EN
   task automatic test_ovf();
      launch(16'h7FFF, 16'h0001, 1'b0);
      repeat (NG) @(negedge clk);
      n_checks++;
      if (ovf !== 1'b1 || sum !== 16'h8000) $display("FAIL ovf_pos: got ovf=%b sum=%h want 1 8000", ovf, sum);
      else n_pass++;
      launch(16'h8000, 16'hFFFF, 1'b0);
      repeat (NG) @(negedge clk);
      n_checks++;
      if (ovf !== 1'b1 || sum !== 16'h7FFF || cout !== 1'b1)
         $display("FAIL ovf_neg: got ovf=%b sum=%h cout=%b want 1 7fff 1", ovf, sum, cout);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
`ifdef CLA_OVF_EN
      test_ovf();
`endif
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
